share_encoder: RTL

- Producer side of the masked-adder share interface: accepts plaintext operands a, b and carry-in, and emits Boolean share pairs (a0,a1), (b0,b1) for the masked ripple-carry adder.
- Fresh masks come from an internal Galois LFSR that can be reseeded at runtime.
- Single-entry valid/ready pipeline stage on both sides; one transaction in flight at a time.

---
 rtl/share_encoder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/share_encoder.sv
// share_encoder
//   Producer side of the masked-adder share interface. Captures plaintext
//   operands a, b and carry-in, then emits Boolean share pairs
//   (a0,a1), (b0,b1) for the masked ripple-carry adder. The masks come from
//   an internal Galois LFSR, which can be reseeded at runtime.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready is high only in IDLE)
//   a, b, c_in          plaintext operands and unmasked carry-in
//   seed_load, seed     reload the LFSR (a zero seed is replaced by SEED)
//   out_valid/out_ready share handshake (out_valid is high only in HOLD)
//   a0, a1, b0, b1      share pairs with a0^a1 == a and b0^b1 == b
//   c_q                 registered carry-in
//   tx_count            completed transactions, wraps from 255 to 0
//
// 2*WIDTH must not exceed LFSR_W, because both masks are sliced from one
// LFSR state.
module share_encoder #(
    parameter int unsigned          WIDTH  = 4,
    parameter int unsigned          LFSR_W = 16,
    parameter logic [LFSR_W-1:0]    SEED   = 16'hACE1,
    parameter logic [LFSR_W-1:0]    TAPS   = 16'hB400
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              c_in,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  a0,
    output logic [WIDTH-1:0]  a1,
    output logic [WIDTH-1:0]  b0,
    output logic [WIDTH-1:0]  b1,
    output logic              c_q,
    output logic [7:0]        tx_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MASK = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state;
    logic [LFSR_W-1:0]  lfsr;
    logic [LFSR_W-1:0]  lfsr_step;
    logic [WIDTH-1:0]   a_hold;
    logic [WIDTH-1:0]   b_hold;
    logic               c_hold;
    logic [WIDTH-1:0]   m_a;
    logic [WIDTH-1:0]   m_b;

    // Galois right-shift step. The tap mask is applied when the bit that
    // shifts out is 1.
    always_comb begin
        lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
        m_a       = lfsr[WIDTH-1:0];
        m_b       = lfsr[2*WIDTH-1:WIDTH];
    end

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lfsr      <= SEED;
            a_hold    <= '0;
            b_hold    <= '0;
            c_hold    <= 1'b0;
            a0        <= '0;
            a1        <= '0;
            b0        <= '0;
            b1        <= '0;
            c_q       <= 1'b0;
            out_valid <= 1'b0;
            tx_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_hold <= a;
                        b_hold <= b;
                        c_hold <= c_in;
                        state  <= MASK;
                    end
                end
                MASK: begin
                    // The masks come from the LFSR value before this edge,
                    // even if a seed load lands on the same edge.
                    a0        <= m_a;
                    a1        <= a_hold ^ m_a;
                    b0        <= m_b;
                    b1        <= b_hold ^ m_b;
                    c_q       <= c_hold;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        tx_count  <= tx_count + 8'd1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase

            // A seed load wins over the MASK step. Zero is replaced by SEED
            // so that the LFSR never locks up in the all-zero state.
            if (seed_load) begin
                lfsr <= (seed == '0) ? SEED : seed;
            end else if (state == MASK) begin
                lfsr <= lfsr_step;
            end
        end
    end

endmodule
